merge2_arb: RTL and testbench

//  Two-input packet merge for the NoC router: the return-direction counterpart of the

---
 rtl/merge2_arb_if.sv | 63 ++++++
 rtl/merge2_arb.sv | 135 +++++++++++++
 tb/tb_merge2_arb.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/merge2_arb_if.sv
// Handshake bundle for the two-input merge: two packet inputs, select-token
// output, merged packet output and the forwarded-packet counter.
interface merge2_arb_if #(
    parameter int unsigned W     = 9,
    parameter int unsigned CNT_W = 8
);
    // Input 0 packet channel
    logic [W-1:0]     in0_data;
    logic             in0_valid;
    logic             in0_ready;

    // Input 1 packet channel
    logic [W-1:0]     in1_data;
    logic             in1_valid;
    logic             in1_ready;

    // Select token channel
    logic             s_data;
    logic             s_valid;
    logic             s_ready;

    // Merged packet channel
    logic [W-1:0]     out_data;
    logic             out_valid;
    logic             out_ready;

    // Forwarded-packet count
    logic [CNT_W-1:0] pkt_count;

    // Merge block side
    modport slave (
        input  in0_data,
        input  in0_valid,
        output in0_ready,
        input  in1_data,
        input  in1_valid,
        output in1_ready,
        output s_data,
        output s_valid,
        input  s_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output pkt_count
    );

    // Producer/consumer side
    modport master (
        output in0_data,
        output in0_valid,
        input  in0_ready,
        output in1_data,
        output in1_valid,
        input  in1_ready,
        input  s_data,
        input  s_valid,
        output s_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  pkt_count
    );
endinterface

// File: rtl/merge2_arb.sv
// Two-input round-robin packet merge. Accepts one packet from In0 or In1,
// optionally announces the winning index on the S token channel, then forwards
// the packet on Out. Priority flips to the other input after each delivery.
module merge2_arb #(
    parameter int unsigned W        = 9,
    parameter int unsigned SEND_SEL = 1,
    parameter int unsigned CNT_W    = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    merge2_arb_if.slave  bus
);

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_SEND_S = 2'b01;
    localparam logic [1:0] ST_SEND_D = 2'b10;

    logic [1:0]       state_q,     state_d;
    logic             prio_q,      prio_d;
    logic             sel_q,       sel_d;
    logic [W-1:0]     hold_q,      hold_d;
    logic             s_valid_q,   s_valid_d;
    logic             s_data_q,    s_data_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q,  out_data_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;

    logic             any_valid_c;
    logic             grant_c;
    logic             accept_c;
    logic [W-1:0]     in_data_c;

    // Arbitration: sole valid input wins, otherwise the priority holder wins
    always_comb begin
        any_valid_c = bus.in0_valid | bus.in1_valid;
        if (bus.in0_valid && bus.in1_valid) begin
            grant_c = prio_q;
        end else begin
            grant_c = bus.in1_valid;
        end
        in_data_c = grant_c ? bus.in1_data : bus.in0_data;
        accept_c  = rst_n && (state_q == ST_IDLE) && any_valid_c;
    end

    assign bus.in0_ready = accept_c && !grant_c;
    assign bus.in1_ready = accept_c &&  grant_c;

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        sel_d       = sel_q;
        hold_d      = hold_q;
        s_valid_d   = s_valid_q;
        s_data_d    = s_data_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    hold_d = in_data_c;
                    sel_d  = grant_c;
                    if (SEND_SEL != 0) begin
                        state_d   = ST_SEND_S;
                        s_valid_d = 1'b1;
                        s_data_d  = grant_c;
                    end else begin
                        // No token phase: packet goes straight to the output
                        state_d     = ST_SEND_D;
                        out_valid_d = 1'b1;
                        out_data_d  = in_data_c;
                    end
                end
            end

            ST_SEND_S: begin
                if (bus.s_ready) begin
                    state_d     = ST_SEND_D;
                    s_valid_d   = 1'b0;
                    out_valid_d = 1'b1;
                    out_data_d  = hold_q;
                end
            end

            ST_SEND_D: begin
                if (bus.out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    cnt_d       = cnt_q + CNT_W'(1);
                    prio_d      = ~sel_q;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                s_valid_d   = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight packet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            prio_q      <= 1'b0;
            sel_q       <= 1'b0;
            hold_q      <= '0;
            s_valid_q   <= 1'b0;
            s_data_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            sel_q       <= sel_d;
            hold_q      <= hold_d;
            s_valid_q   <= s_valid_d;
            s_data_q    <= s_data_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.s_valid   = s_valid_q;
    assign bus.s_data    = s_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.pkt_count = cnt_q;

endmodule

// File: tb/tb_merge2_arb.sv
// Bench for merge2_arb: directed scenarios plus a randomized phase, all
// checked against a packet-level model (pending inputs, priority bit, count).
module tb_merge2_arb;

    localparam int unsigned W      = 9;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned CNT2_W = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    merge2_arb_if #(.W(W), .CNT_W(CNT_W))  bus ();
    merge2_arb_if #(.W(W), .CNT_W(CNT2_W)) bus2 ();

    merge2_arb #(.W(W), .SEND_SEL(1), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    merge2_arb #(.W(W), .SEND_SEL(0), .CNT_W(CNT2_W)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int passed = 0;
    int total  = 0;

    // Packet-level reference model
    bit           prio_m;
    int           cnt_m;
    int           cnt2_m;
    bit           pend_v [2];
    logic [W-1:0] pend_d [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_inputs();
        bus.in0_valid = pend_v[0];
        bus.in0_data  = pend_d[0];
        bus.in1_valid = pend_v[1];
        bus.in1_data  = pend_d[1];
    endtask

    function automatic bit model_grant();
        if (pend_v[0] && pend_v[1]) return prio_m;
        return pend_v[1];
    endfunction

    // One complete transaction: accept, token (with stalls), packet (with stalls)
    task automatic do_packet(input int s_stall, input int o_stall);
        bit           g;
        logic [W-1:0] exp_d;
        drive_inputs();
        #1;
        g     = model_grant();
        exp_d = pend_d[g];
        check("in0_ready_idle", 32'(bus.in0_ready), 32'(!g));
        check("in1_ready_idle", 32'(bus.in1_ready), 32'(g));
        step();
        pend_v[g] = 1'b0;
        drive_inputs();
        #1;
        check("s_valid_first", 32'(bus.s_valid), 32'd1);
        check("s_data_first", 32'(bus.s_data), 32'(g));
        check("out_valid_during_s", 32'(bus.out_valid), 32'd0);
        for (int i = 0; i < s_stall; i++) begin
            step();
            check("s_data_stall", 32'(bus.s_data), 32'(g));
            check("s_valid_stall", 32'(bus.s_valid), 32'd1);
            check("out_valid_stall_s", 32'(bus.out_valid), 32'd0);
            check("ready_stall_s", 32'({bus.in0_ready, bus.in1_ready}), 32'd0);
        end
        bus.s_ready = 1'b1;
        step();
        bus.s_ready = 1'b0;
        check("s_valid_after", 32'(bus.s_valid), 32'd0);
        check("out_valid_first", 32'(bus.out_valid), 32'd1);
        check("out_data_first", 32'(bus.out_data), 32'(exp_d));
        for (int i = 0; i < o_stall; i++) begin
            step();
            check("out_data_stall", 32'(bus.out_data), 32'(exp_d));
            check("out_valid_stall", 32'(bus.out_valid), 32'd1);
            check("ready_stall_o", 32'({bus.in0_ready, bus.in1_ready}), 32'd0);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        cnt_m  = (cnt_m + 1) % 256;
        prio_m = !g;
        check("out_valid_after", 32'(bus.out_valid), 32'd0);
        check("pkt_count", 32'(bus.pkt_count), 32'(cnt_m));
    endtask

    // Asynchronous reset mid-run: outputs must clear before the next edge
    task automatic reset_mid_run();
        rst_n = 1'b0;
        #1;
        check("rst_s_valid", 32'(bus.s_valid), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_readies", 32'({bus.in0_ready, bus.in1_ready}), 32'd0);
        check("rst_pkt_count", 32'(bus.pkt_count), 32'd0);
        check("rst_pkt_count2", 32'(bus2.pkt_count), 32'd0);
        prio_m    = 1'b0;
        cnt_m     = 0;
        cnt2_m    = 0;
        pend_v[0] = 1'b0;
        pend_v[1] = 1'b0;
        drive_inputs();
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        prio_m    = 1'b0;
        cnt_m     = 0;
        cnt2_m    = 0;
        pend_v[0] = 1'b0;
        pend_v[1] = 1'b0;
        pend_d[0] = '0;
        pend_d[1] = '0;
        drive_inputs();
        bus.s_ready    = 1'b0;
        bus.out_ready  = 1'b0;
        bus2.in0_valid = 1'b0;
        bus2.in0_data  = '0;
        bus2.in1_valid = 1'b0;
        bus2.in1_data  = '0;
        bus2.s_ready   = 1'b0;
        bus2.out_ready = 1'b0;

        // Power-on reset values
        step();
        check("init_s_valid", 32'(bus.s_valid), 32'd0);
        check("init_s_data", 32'(bus.s_data), 32'd0);
        check("init_out_valid", 32'(bus.out_valid), 32'd0);
        check("init_out_data", 32'(bus.out_data), 32'd0);
        check("init_pkt_count", 32'(bus.pkt_count), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("idle_no_ready", 32'({bus.in0_ready, bus.in1_ready}), 32'd0);

        // Single packet on in0
        pend_v[0] = 1'b1;
        pend_d[0] = 9'h1A5;
        do_packet(0, 0);

        // Both inputs held: alternation, then reload pair
        pend_v[0] = 1'b1; pend_d[0] = 9'h011;
        pend_v[1] = 1'b1; pend_d[1] = 9'h122;
        do_packet(0, 0);
        do_packet(0, 0);
        pend_v[0] = 1'b1; pend_d[0] = 9'h033;
        pend_v[1] = 1'b1; pend_d[1] = 9'h144;
        do_packet(0, 0);
        do_packet(0, 0);

        // Long stalls on token and packet channels
        pend_v[0] = 1'b1; pend_d[0] = 9'h0F0;
        pend_v[1] = 1'b1; pend_d[1] = 9'h10F;
        do_packet(5, 3);
        do_packet(1, 1);

        // Reset while a token is pending
        pend_v[1] = 1'b1; pend_d[1] = 9'h0AA;
        drive_inputs();
        step();
        check("pre_rst_s_valid", 32'(bus.s_valid), 32'd1);
        reset_mid_run();

        // Make prio favour in1, then reset while in SEND_D with out_ready low
        pend_v[0] = 1'b1; pend_d[0] = 9'h055;
        do_packet(0, 0);
        pend_v[0] = 1'b1; pend_d[0] = 9'h066;
        drive_inputs();
        step();
        pend_v[0] = 1'b0;
        drive_inputs();
        bus.s_ready = 1'b1;
        step();
        bus.s_ready = 1'b0;
        step();
        check("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
        reset_mid_run();
        pend_v[0] = 1'b1; pend_d[0] = 9'h077;
        pend_v[1] = 1'b1; pend_d[1] = 9'h188;
        do_packet(0, 0);
        do_packet(0, 0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend_v[i] && ($urandom_range(0, 1) == 1)) begin
                    pend_v[i] = 1'b1;
                    pend_d[i] = W'($urandom);
                end
            end
            if (!pend_v[0] && !pend_v[1]) begin
                pend_v[n % 2] = 1'b1;
                pend_d[n % 2] = W'($urandom);
            end
            do_packet(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        // No-token variant with a 2-bit counter: 5 packets on in1
        for (int n = 0; n < 5; n++) begin
            logic [W-1:0] d2;
            int           stall;
            d2    = W'($urandom);
            stall = int'($urandom_range(0, 2));
            bus2.in1_valid = 1'b1;
            bus2.in1_data  = d2;
            #1;
            check("m2_in1_ready", 32'(bus2.in1_ready), 32'd1);
            check("m2_in0_ready", 32'(bus2.in0_ready), 32'd0);
            step();
            bus2.in1_valid = 1'b0;
            check("m2_out_valid", 32'(bus2.out_valid), 32'd1);
            check("m2_out_data", 32'(bus2.out_data), 32'(d2));
            check("m2_s_valid", 32'(bus2.s_valid), 32'd0);
            for (int i = 0; i < stall; i++) begin
                step();
                check("m2_out_data_stall", 32'(bus2.out_data), 32'(d2));
                check("m2_s_valid_stall", 32'(bus2.s_valid), 32'd0);
            end
            bus2.out_ready = 1'b1;
            step();
            bus2.out_ready = 1'b0;
            cnt2_m = (cnt2_m + 1) % 4;
            check("m2_out_valid_after", 32'(bus2.out_valid), 32'd0);
            check("m2_pkt_count", 32'(bus2.pkt_count), 32'(cnt2_m));
        end
        check("m2_final_count", 32'(bus2.pkt_count), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
